// File: rtl/bamboo_pkg.sv
// Shared definitions for the bamboo core's load/store unit.
//   - funct3 access-width encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - LSU memory-stage state enum (IDLE / REQ / RESP)
package bamboo_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Bundle of the memory stage's handshake and bus signals.
//   execute side : ex_valid_i / ex_ready_o, load_i, store_i, funct3_i,
//                  addr_i, wdata_i, rd_i
//   data memory  : dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o,
//                  dmem_wdata_o, dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
//   writeback    : wb_valid_o, wb_we_o, wb_rd_o, wb_data_o,
//                  misalign_o, bus_err_o
// Modport slave is the stage's view, master is the surrounding core/bench.
//
// Handshakes: an instruction transfers on a rising edge where
// ex_valid_i & ex_ready_o; a bus request transfers on a rising edge where
// dmem_req_o & dmem_gnt_i, and req/addr/we/be/wdata stay stable until then;
// read data is taken on the first rising edge with dmem_rvalid_i after the
// grant; wb_valid_o is a one-cycle pulse with no back-pressure.
interface lsu_mem_stage_if;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic        load_i;
  logic        store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;

  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  logic        wb_valid_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;
  logic        bus_err_o;

  modport slave (
    input  ex_valid_i, load_i, store_i, funct3_i, addr_i, wdata_i, rd_i,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    output ex_ready_o,
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, misalign_o, bus_err_o
  );

  modport master (
    output ex_valid_i, load_i, store_i, funct3_i, addr_i, wdata_i, rd_i,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    input  ex_ready_o,
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, misalign_o, bus_err_o
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the memory stage.
//   i_funct3, i_off  : access width/sign and byte offset addr[1:0]
//   i_is_store       : selects the store legality rules
//   i_wdata          : store data (rs2), i_rdata : word read from memory
//   o_be, o_wdata    : byte enables and lane-replicated store data
//   o_misalign       : misaligned access or illegal width
//   o_load           : extracted, sign/zero-extended load value
module lsu_align
  import bamboo_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic        i_is_store,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  output logic [31:0] o_load
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = i_wdata;
    o_misalign = 1'b0;
    o_load     = 32'h0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be       = 4'b0001 << i_off;
        o_wdata    = {4{i_wdata[7:0]}};
        // Stores have no unsigned variants.
        o_misalign = i_is_store && (i_funct3 == F3_BU);
        o_load     = (i_funct3 == F3_BU) ? {24'h0, w_byte}
                                         : {{24{w_byte[7]}}, w_byte};
      end
      F3_H, F3_HU: begin
        o_be       = 4'b0011 << i_off;
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_off[0] || (i_is_store && (i_funct3 == F3_HU));
        o_load     = (i_funct3 == F3_HU) ? {16'h0, w_half}
                                         : {{16{w_half[15]}}, w_half};
      end
      F3_W: begin
        o_be       = 4'b1111;
        o_misalign = (i_off != 2'b00);
        o_load     = i_rdata;
      end
      default: o_misalign = 1'b1;
    endcase
  end
endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage between execute and writeback.
//   clk, rst_n   : clock and asynchronous active-low reset
//   bus          : execute / data-memory / writeback signals (slave view)
//   o_dbg_state  : current FSM state
// Non-memory results pass straight to writeback one cycle after accept.
// Memory ops run IDLE -> REQ -> (RESP) -> IDLE with a shared timeout
// counter; every accepted instruction produces exactly one wb_valid_o pulse.
module lsu_mem_stage
  import bamboo_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_mem_stage_if.slave bus,
  output lsu_state_e     o_dbg_state
);
  localparam logic [7:0] LP_CNT_LAST = 8'(MAX_WAIT - 1);

  lsu_state_e  r_state, w_state_nxt;
  logic [7:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [4:0]  r_rd;

  logic        r_dmem_req, r_dmem_we;
  logic [31:0] r_dmem_addr, r_dmem_wdata;
  logic [3:0]  r_dmem_be;
  logic        r_wb_valid, r_wb_we, r_misalign, r_bus_err;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic        w_ready, w_accept, w_is_mem, w_is_store, w_timeout;
  logic        w_st_done, w_ld_done, w_abort;
  logic [2:0]  w_align_f3;
  logic [1:0]  w_align_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep, w_load_val;
  logic        w_misalign;

  assign w_ready    = (r_state == LSU_IDLE);
  assign w_accept   = bus.ex_valid_i & w_ready;
  assign w_is_mem   = bus.load_i | bus.store_i;
  // load_i wins when decode raises both flags.
  assign w_is_store = bus.store_i & ~bus.load_i;
  assign w_timeout  = (r_cnt == LP_CNT_LAST);

  // In IDLE the aligner checks the incoming op; afterwards it extracts
  // load data using the width/offset captured at accept.
  assign w_align_f3  = w_ready ? bus.funct3_i   : r_funct3;
  assign w_align_off = w_ready ? bus.addr_i[1:0] : r_off;

  lsu_align u_align (
    .i_funct3   (w_align_f3),
    .i_off      (w_align_off),
    .i_is_store (w_is_store),
    .i_wdata    (bus.wdata_i),
    .i_rdata    (bus.dmem_rdata_i),
    .o_be       (w_be),
    .o_wdata    (w_wdata_rep),
    .o_misalign (w_misalign),
    .o_load     (w_load_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LSU_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A load grant is progress, not completion, so the timeout still wins
  // over it; a store grant or load rvalid completes and beats the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_st_done   = 1'b0;
    w_ld_done   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        if (w_accept && w_is_mem && !w_misalign) w_state_nxt = LSU_REQ;
      end
      LSU_REQ: begin
        if (bus.dmem_gnt_i && r_dmem_we) begin
          w_st_done   = 1'b1;
          w_state_nxt = LSU_IDLE;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = LSU_IDLE;
        end else if (bus.dmem_gnt_i) begin
          w_state_nxt = LSU_RESP;
        end
      end
      LSU_RESP: begin
        if (bus.dmem_rvalid_i) begin
          w_ld_done   = 1'b1;
          w_state_nxt = LSU_IDLE;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = LSU_IDLE;
        end
      end
      default: w_state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 8'h0;
      r_funct3     <= 3'b000;
      r_off        <= 2'b00;
      r_rd         <= 5'd0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'h0;
      r_dmem_be    <= 4'h0;
      r_dmem_wdata <= 32'h0;
      r_wb_valid   <= 1'b0;
      r_wb_we      <= 1'b0;
      r_wb_rd      <= 5'd0;
      r_wb_data    <= 32'h0;
      r_misalign   <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;

      if (!w_ready) r_cnt <= r_cnt + 8'd1;

      if (w_accept) begin
        r_funct3 <= bus.funct3_i;
        r_off    <= bus.addr_i[1:0];
        r_rd     <= bus.rd_i;
        r_cnt    <= 8'h0;
        if (!w_is_mem) begin
          r_wb_valid <= 1'b1;
          r_wb_we    <= 1'b1;
          r_wb_rd    <= bus.rd_i;
          r_wb_data  <= bus.addr_i;
        end else if (w_misalign) begin
          r_wb_valid <= 1'b1;
          r_misalign <= 1'b1;
          r_wb_rd    <= bus.rd_i;
          r_wb_data  <= 32'h0;
        end else begin
          r_dmem_req   <= 1'b1;
          r_dmem_we    <= w_is_store;
          r_dmem_addr  <= {bus.addr_i[31:2], 2'b00};
          r_dmem_be    <= w_be;
          r_dmem_wdata <= w_wdata_rep;
        end
      end

      if (r_state == LSU_REQ && (bus.dmem_gnt_i || w_abort)) r_dmem_req <= 1'b0;

      if (w_st_done) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_data  <= 32'h0;
      end
      if (w_ld_done) begin
        r_wb_valid <= 1'b1;
        r_wb_we    <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_data  <= w_load_val;
      end
      if (w_abort) begin
        r_wb_valid <= 1'b1;
        r_bus_err  <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_data  <= 32'h0;
      end
    end
  end

  assign bus.ex_ready_o   = w_ready;
  assign bus.dmem_req_o   = r_dmem_req;
  assign bus.dmem_we_o    = r_dmem_we;
  assign bus.dmem_addr_o  = r_dmem_addr;
  assign bus.dmem_be_o    = r_dmem_be;
  assign bus.dmem_wdata_o = r_dmem_wdata;
  assign bus.wb_valid_o   = r_wb_valid;
  assign bus.wb_we_o      = r_wb_we;
  assign bus.wb_rd_o      = r_wb_rd;
  assign bus.wb_data_o    = r_wb_data;
  assign bus.misalign_o   = r_misalign;
  assign bus.bus_err_o    = r_bus_err;
  assign o_dbg_state      = r_state;
endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Memory-access stage sitting directly downstream of `execute`. It takes the ALU result (`alu_res_o`, the effective address or plain result) and rs2 store data. Memory ops run through a req/gnt/rvalid data-memory handshake with byte-lane alignment and load sign/zero extension. All results, memory or not, are delivered to writeback as a single-cycle valid pulse.

## Interface
- `MAX_WAIT`, default 255: cycles a bus transaction may stay in REQ+RESP before abort; range 2..255.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ex_valid_i`  in  1  execute offers an instruction.
- `ex_ready_o`  out  1  stage can accept; high only in IDLE.
- `load_i`, `store_i`  in  1  memory-op flags from decode.
- `funct3_i`  in  3  access width/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr_i`  in  32  ALU result / effective address.
- `wdata_i`  in  32  store data (rs2).
- `rd_i`  in  5  destination register.
- `dmem_req_o`  out  1  bus request.
- `dmem_we_o`  out  1  1 = write.
- `dmem_addr_o`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_be_o`  out  4  byte enables.
- `dmem_wdata_o`  out  32  lane-replicated store data.
- `dmem_gnt_i`  in  1  request accepted.
- `dmem_rvalid_i`  in  1  read data valid.
- `dmem_rdata_i`  in  32  read data.
- `wb_valid_o`  out  1  one-cycle result pulse.
- `wb_we_o`  out  1  register write enable, qualifies `wb_data_o`.
- `wb_rd_o`  out  5  destination register.
- `wb_data_o`  out  32  result.
- `misalign_o`  out  1  one-cycle pulse: misaligned or illegal width.
- `bus_err_o`  out  1  one-cycle pulse: timeout abort.

## Operation
- **Accept:** `ex_valid_i & ex_ready_o` at a rising edge. Inputs are captured into registers.
- **load_i and store_i both high:** treated as a load.
- **Non-memory op:** next cycle `wb_valid_o=1`, `wb_we_o=1`, `wb_data_o=addr_i`. No bus activity.
- **Illegal width:** load funct3 011/110/111, or store funct3 ≥ 011. Handled the same as a misaligned access.
- **Alignment rules:**
  - H/HU require `addr[0]=0`.
  - W requires `addr[1:0]=00`.
  - On a violation, next cycle: `misalign_o=1`, `wb_valid_o=1`, `wb_we_o=0`. No request is issued.
- **Store lanes (off = addr[1:0]):**
  - SB: `be=0001<<off`, `wdata={4{b}}`.
  - SH: `be=0011<<off`, `wdata={2{h}}`.
  - SW: `be=1111`.
- **Load extraction:**
  - B/BU: byte `rdata[8*off+:8]`.
  - H/HU: half `rdata[16*off[1]+:16]`.
  - Signed widths sign-extend; U widths zero-extend.
- **State machine: IDLE, REQ, RESP.**
  - IDLE → REQ on accepting an aligned memory op.
  - REQ: `dmem_req_o=1`, with addr/we/be/wdata held stable until `dmem_gnt_i`.
  - REQ + gnt, store: → IDLE, with a `wb_valid_o` pulse (`wb_we_o=0`) in the following cycle.
  - REQ + gnt, load: → RESP.
  - RESP + `dmem_rvalid_i`: → IDLE, with `wb_valid_o=1`, `wb_we_o=1`, extracted data in the following cycle.
- **Timeout counter:**
  - Cleared on entry to REQ; increments each cycle spent in REQ or RESP.
  - When the count reaches MAX_WAIT with no completion: abort to IDLE. Next cycle: `bus_err_o=1`, `wb_valid_o=1`, `wb_we_o=0`.
  - Completion in the same cycle wins over timeout.
- **Ignored inputs:** `dmem_rvalid_i` outside RESP; `dmem_gnt_i` outside REQ.
- **Reset:** async `rst_n` low forces IDLE, clears the counter, and drives every output to 0 except `ex_ready_o=1`. An in-flight transaction is abandoned and its late rvalid is ignored.

## Timing
- All outputs are registered except `ex_ready_o`, which is decoded from state.
- Let N be the accept edge.
- **Pass-through or misaligned op:** `wb_valid_o` during cycle N+1; `ex_ready_o` stays high.
- **Store with immediate gnt:** req during N+1; `wb_valid_o` during N+2; ready again in N+2.
- **Load with immediate gnt:**
  - req during N+1.
  - rvalid no earlier than N+2; rvalid in the gnt cycle is ignored.
  - `wb_valid_o` one cycle after rvalid.
- **Throughput:** one instruction per cycle for non-memory ops; a memory op blocks until complete.
- **Output pulses:** each accepted instruction yields exactly one `wb_valid_o` pulse. `misalign_o` and `bus_err_o` coincide with that pulse.

## Structure
- **Shared package `bamboo_pkg`:**
  - funct3 width encodings: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - LSU state enum: IDLE/REQ/RESP.
- **Sub-module `lsu_align`** (combinational): takes funct3, off and store data; produces be, replicated wdata, misalign flag and the extracted load value.
- The FSM, timeout counter and registers stay in `lsu_mem_stage`.

## Test plan
- Non-mem op, `addr_i=0x00001234`, `rd=5` → N+1: valid, we=1, data `0x00001234`, rd 5; no req.
- SW `addr=0x100`, data `0xDEADBEEF`, gnt immediate → one req cycle: addr `0x100`, be `1111`, wdata `0xDEADBEEF`; wb pulse at N+2 with we=0.
- SB `addr=0x103`, data `0x000000A5` → addr `0x100`, be `1000`, wdata `0xA5A5A5A5`.
- LB `addr=0x202`, rdata `0x12803456` → `wb_data 0xFFFFFF80`; LBU same stimulus → `0x00000080`; LHU `addr=0x202` → `0x00001280`.
- LH `addr=0x201` → `misalign_o` pulse at N+1, wb valid with we=0, `dmem_req_o` never high.
- Load with gnt after 3 cycles and rvalid 2 cycles later → req/addr stable throughout, `ex_ready_o` low, exactly one wb pulse.
- `MAX_WAIT=4`, gnt never asserted → abort after 4 cycles, then `bus_err_o` pulse.
- Reset in RESP, then rvalid → ignored; `ex_ready_o=1`; no wb pulse.
